sequence_detector: RTL and testbench
====================================

# sequence_detector

Serial bit-stream pattern detector for the fixed pattern 0101, first bit first. It samples one input bit per clock. It asserts a one-cycle registered flag after the last bit of each match. It sits between a serial data source and any downstream logic that counts or reacts to pattern occurrences. Detection is non-overlapping by default; overlapping mode is selectable by parameter.

## Interface
- OVERLAP, default 0: 0 = non-overlapping detection (search restarts from scratch after a match); 1 = overlapping (trailing "01" of a match counts as the prefix of the next one).
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- in  input  1  serial data bit, sampled on every rising clk edge while rst_n=1.
- out  output  1  match flag, registered; high for exactly one cycle per detected 0101.

## Operation
- Moore FSM with five states:
  - IDLE: no useful prefix.
  - S0: seen "0".
  - S01: seen "01".
  - S010: seen "010".
  - DET: seen "0101".
- Transitions, on input 0 / input 1:
  - IDLE: 0 → S0, 1 → IDLE.
  - S0: 0 → S0, 1 → S01.
  - S01: 0 → S010, 1 → IDLE.
  - S010: 0 → S0, 1 → DET.
  - DET, OVERLAP=0: 0 → S0, 1 → IDLE.
  - DET, OVERLAP=1: 0 → S010, 1 → IDLE.
- out = 1 iff the state register holds DET. Decode out from the registered state, or register it alongside the state; no combinational path from in to out.
- Encoding choice is free (binary or one-hot). Unused encodings must recover to IDLE on the next edge with out=0.
- No enable input: every rising edge with rst_n=1 consumes one bit.

## Timing
- Reset: rst_n=0 forces state=IDLE and out=0 immediately, with no clock required, and holds them while low.
- First sample occurs on the first rising edge after rst_n deasserts.
- Reset asserted mid-sequence discards any partial prefix. After release, a full fresh 0101 is required.
- Latency: the edge that samples the final "1" of the pattern sets out=1. out stays high for that one clock period and returns to 0 on the next edge, unless a new match completes on that edge.
  - A new match on the very next edge is impossible for this pattern, so out is never high two consecutive cycles.
- Back-to-back matches, input 010101:
  - OVERLAP=0: one pulse, after the 4th bit.
  - OVERLAP=1: two pulses, after the 4th and 6th bits (two cycles apart).
- in must be stable around the rising edge (setup/hold). Changes between edges have no effect.

## Test plan
- Reset: hold rst_n=0 with in=1 for two clocks, toggling in → out=0 and state=IDLE throughout; release between edges → no pulse.
- Basic match, OVERLAP=0: bits 1,0,1,0,1,1,1,1 → exactly one out pulse, in the cycle after the 5th bit (the "1" completing 0101); out=0 elsewhere.
- Repeated pattern, OVERLAP=0: bits 0,1,0,1,0,1,1 → single pulse after the 4th bit; no pulse after the 6th bit.
- Repeated pattern, OVERLAP=1: same bits 0,1,0,1,0,1,1 → pulses after the 4th and 6th bits, each one cycle wide.
- Near-misses: 0,1,1,0,1 and 0,0,1,0,0,1 → no pulse. Then 0,0,1,0,1 → pulse after the last bit; the S0 self-loop on repeated 0s must hold the prefix.
- Async reset mid-pattern: bits 0,1,0, then pulse rst_n low between edges, then 1 → no pulse; then 0,1,0,1 → pulse after the last bit.

Source files
------------

// File: rtl/sequence_detector.sv
// sequence_detector
//   Serial pattern detector for "0101" (first bit first). One bit of `in` is
//   consumed on every rising clk edge while rst_n is high. `out` is a Moore
//   output decoded from the registered state and is high for exactly one
//   cycle after the edge that samples the final "1" of each match.
//
// Parameters
//   OVERLAP  0: search restarts after a match (non-overlapping)
//            1: trailing "01" of a match seeds the next match
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset (state -> IDLE, out -> 0)
//   in     in   serial data bit
//   out    out  match flag, one cycle per detected 0101
module sequence_detector #(
  parameter bit OVERLAP = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic out
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,  // no useful prefix
    S0   = 3'd1,  // seen "0"
    S01  = 3'd2,  // seen "01"
    S010 = 3'd3,  // seen "010"
    DET  = 3'd4   // seen "0101"
  } state_t;

  state_t state, state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    unique case (state)
      IDLE: state_nxt = in ? IDLE : S0;
      S0:   state_nxt = in ? S01  : S0;
      S01:  state_nxt = in ? IDLE : S010;
      S010: state_nxt = in ? DET  : S0;
      // After a match, a following 0 either starts a fresh prefix or, when
      // overlapping, extends the match's trailing "01" into "010".
      DET:  state_nxt = in ? IDLE : (OVERLAP ? S010 : S0);
      // Unused encodings fall back to IDLE on the next edge.
      default: state_nxt = IDLE;
    endcase
  end

  // Pure state decode: no combinational path from `in`.
  assign out = (state == DET);

endmodule

// File: tb/tb_sequence_detector.sv
// tb_sequence_detector
//   Drives a shared bit stream into two detectors (non-overlapping and
//   overlapping) and checks both flags against tabulated expectations via a
//   small expected-result queue.
module tb_sequence_detector;

  logic clk;
  logic rst_n;
  logic in;
  logic out0;
  logic out1;

  sequence_detector #(.OVERLAP(1'b0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .out   (out0)
  );

  sequence_detector #(.OVERLAP(1'b1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .out   (out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit b;    // bit to drive
    bit e0;   // expected out, OVERLAP=0, after the sampling edge
    bit e1;   // expected out, OVERLAP=1
    int grp;  // stimulus group; a reset precedes each new group
  } vec_t;

  typedef struct {
    bit e0;
    bit e1;
    string name;
  } exp_t;

  exp_t sb[$];
  int n_vec;
  int n_err;

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: out=%b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one bit between edges, let the next rising edge sample it, then
  // compare both flags shortly after that edge.
  task automatic apply_bit(input bit b, input bit e0, input bit e1, input string name);
    exp_t e;
    @(negedge clk);
    in = b;
    sb.push_back('{e0, e1, name});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.name, "/ov0"}, out0, e.e0);
    check({e.name, "/ov1"}, out1, e.e1);
  endtask

  // Called just after a rising edge. Asserts reset between edges (output must
  // clear without a clock), holds it over two edges with `in` toggling, then
  // releases before the next edge.
  task automatic do_reset(input string name);
    #1;
    rst_n = 1'b0;
    #1;
    check({name, "/async0"}, out0, 1'b0);
    check({name, "/async1"}, out1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in = ~in;
      @(posedge clk);
      #1;
      check({name, "/hold0"}, out0, 1'b0);
      check({name, "/hold1"}, out1, 1'b0);
    end
    #2;
    rst_n = 1'b1;
  endtask

  vec_t tbl [31];

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_err = 0;

    tbl = '{
      // basic match: 1,0,1,0,1,1,1,1
      '{1'b1, 1'b0, 1'b0, 0}, '{1'b0, 1'b0, 1'b0, 0}, '{1'b1, 1'b0, 1'b0, 0},
      '{1'b0, 1'b0, 1'b0, 0}, '{1'b1, 1'b1, 1'b1, 0}, '{1'b1, 1'b0, 1'b0, 0},
      '{1'b1, 1'b0, 1'b0, 0}, '{1'b1, 1'b0, 1'b0, 0},
      // repeated pattern: 0,1,0,1,0,1,1
      '{1'b0, 1'b0, 1'b0, 1}, '{1'b1, 1'b0, 1'b0, 1}, '{1'b0, 1'b0, 1'b0, 1},
      '{1'b1, 1'b1, 1'b1, 1}, '{1'b0, 1'b0, 1'b0, 1}, '{1'b1, 1'b0, 1'b1, 1},
      '{1'b1, 1'b0, 1'b0, 1},
      // near-misses 0,1,1,0,1 then 0,0,1,0,0,1, then 0,0,1,0,1 matches
      '{1'b0, 1'b0, 1'b0, 2}, '{1'b1, 1'b0, 1'b0, 2}, '{1'b1, 1'b0, 1'b0, 2},
      '{1'b0, 1'b0, 1'b0, 2}, '{1'b1, 1'b0, 1'b0, 2},
      '{1'b0, 1'b0, 1'b0, 2}, '{1'b0, 1'b0, 1'b0, 2}, '{1'b1, 1'b0, 1'b0, 2},
      '{1'b0, 1'b0, 1'b0, 2}, '{1'b0, 1'b0, 1'b0, 2}, '{1'b1, 1'b0, 1'b0, 2},
      '{1'b0, 1'b0, 1'b0, 2}, '{1'b0, 1'b0, 1'b0, 2}, '{1'b1, 1'b0, 1'b0, 2},
      '{1'b0, 1'b0, 1'b0, 2}, '{1'b1, 1'b1, 1'b1, 2}
    };

    // Reset from time zero: flag must be low before any clock edge.
    rst_n = 1'b0;
    in    = 1'b1;
    #1;
    check("por/ov0", out0, 1'b0);
    check("por/ov1", out1, 1'b0);

    for (int i = 0; i < 31; i++) begin
      if (i == 0 || tbl[i].grp != tbl[i-1].grp)
        do_reset($sformatf("rst_g%0d", tbl[i].grp));
      apply_bit(tbl[i].b, tbl[i].e0, tbl[i].e1, $sformatf("vec%0d_g%0d", i, tbl[i].grp));
    end

    // The last table row leaves both flags high; reset must clear them
    // immediately.
    do_reset("rst_after_match");

    // Reset pulsed mid-pattern: the "010" prefix must be discarded.
    apply_bit(1'b0, 1'b0, 1'b0, "mid_a");
    apply_bit(1'b1, 1'b0, 1'b0, "mid_b");
    apply_bit(1'b0, 1'b0, 1'b0, "mid_c");
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst/ov0", out0, 1'b0);
    check("mid_rst/ov1", out1, 1'b0);
    #1;
    rst_n = 1'b1;
    apply_bit(1'b1, 1'b0, 1'b0, "mid_after_rst");
    apply_bit(1'b0, 1'b0, 1'b0, "mid_fresh_0");
    apply_bit(1'b1, 1'b0, 1'b0, "mid_fresh_1");
    apply_bit(1'b0, 1'b0, 1'b0, "mid_fresh_2");
    apply_bit(1'b1, 1'b1, 1'b1, "mid_fresh_3");
    apply_bit(1'b0, 1'b0, 1'b0, "mid_post");

    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: left=%0d expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
